mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have exactly one clock and one reset, and SHALL list them first in the port list:
- clk, input, 1 bit: the single clock.
- reset, input, 1 bit: synchronous, active-high.

REQ-002 The block SHALL have the following inputs, driven from the M-stage pipeline register:
- valid_M, input, 1: an M-stage instruction is present.
- op_M, input, 4: access type. 0 = none, 1 = LW, 2 = LH, 3 = LHU, 4 = LB, 5 = LBU, 6 = SW, 7 = SH, 8 = SB. Codes 9-15 are treated as none.
- AO_M, input, 32: effective address.
- V2_M, input, 32: store data, right-aligned.
- isExc_M, input, 1: an earlier-stage exception is already pending.
- isOverflow_M, input, 1: the address calculation overflowed.

REQ-003 The block SHALL have the following bus-side ports:
- bus_req, output, 1: request strobe.
- bus_we, output, 1: write enable.
- bus_addr, output, 32: word-aligned address.
- bus_wdata, output, 32: lane-shifted store data.
- bus_byteen, output, 4: byte enables.
- bus_ack, input, 1: responder completion.
- bus_rdata, input, 32: read word.

REQ-004 The block SHALL have the following pipeline-side outputs:
- stall, output, 1: freeze PC, F, D, E and M.
- rdata_W, output, 32: extended load result.
- done, output, 1: access completed this cycle.
- isExc, output, 1: memory exception raised.
- excCode, output, 5: exception cause.

Function
REQ-005 The block SHALL implement a four-state FSM: IDLE, REQ, DONE, EXC.

REQ-006 An access SHALL be requested when valid_M = 1, op_M is 1-8, and isExc_M = 0. With isExc_M = 1 the block SHALL issue no access and SHALL NOT stall.

REQ-007 Checks SHALL be made in IDLE on the cycle the access is requested. The following SHALL raise an address error, excCode 4 (AdEL) for loads and 5 (AdES) for stores:
- LW/SW with AO_M[1:0] != 0.
- LH/LHU/SH with AO_M[0] != 0.
- isOverflow_M = 1.
- An address outside 0x0000-0x2FFF, 0x7F00-0x7F0B and 0x7F10-0x7F1B.
- A halfword or byte access to 0x7F00-0x7F1B.
- A store to 0x7F08-0x7F0B or 0x7F18-0x7F1B.

REQ-008 IDLE SHALL transition as follows:
- Requested access that passes the checks: go to REQ and latch op, address and store data.
- Requested access that fails the checks: go to EXC.
- Otherwise: stay in IDLE.

REQ-009 stall SHALL be combinational:
- 1 in IDLE while an access is requested.
- 1 in REQ.
- 0 in DONE and EXC.

REQ-010 In REQ, bus_req SHALL be 1 and all bus outputs SHALL hold constant until bus_ack = 1 is sampled. On that edge the FSM SHALL go to DONE and capture bus_rdata.

REQ-011 In DONE, done SHALL be 1 for exactly one cycle, rdata_W SHALL be valid, and the FSM SHALL return to IDLE on the next edge.

REQ-012 In EXC, isExc SHALL be 1 and excCode SHALL be valid for exactly one cycle, and the FSM SHALL return to IDLE on the next edge. No bus request SHALL be made for a faulting access.

REQ-013 bus_addr SHALL be {AO[31:2], 2'b00}.

REQ-014 For SW, bus_byteen SHALL be 4'b1111 and bus_wdata SHALL be V2.

REQ-015 For SH, bus_byteen SHALL be 4'b0011 << AO[1:0] and bus_wdata SHALL be {2{V2[15:0]}}.

REQ-016 For SB, bus_byteen SHALL be 4'b0001 << AO[1:0] and bus_wdata SHALL be {4{V2[7:0]}}.

REQ-017 For loads, bus_we SHALL be 0 and bus_byteen SHALL be 4'b1111.

REQ-018 The load result SHALL select the lane by the latched AO[1:0] and extend it to 32 bits:
- LH and LB: sign-extend.
- LHU and LBU: zero-extend.
- LW: pass the word unchanged.

REQ-019 rdata_W SHALL hold its last value outside DONE.

REQ-020 A bus_ack outside REQ SHALL be ignored.

REQ-021 The minimum latency SHALL be 3 cycles (IDLE, REQ, DONE). Each additional cycle before bus_ack SHALL add one cycle of stall. There is no timeout.

REQ-022 Because stall freezes the M stage, the M-stage inputs SHALL remain constant while stall = 1. The block SHALL use only its latched copies after leaving IDLE.

Reset
REQ-023 When reset = 1 on a clock edge, the block SHALL, from the following cycle:
- set the FSM to IDLE;
- set bus_req, bus_we, done and isExc to 0;
- set bus_addr, bus_wdata and rdata_W to 0;
- set bus_byteen to 4'b0000;
- set excCode to 5'd0.

REQ-024 A reset during REQ SHALL drop bus_req on the next cycle. A bus_ack arriving after that reset SHALL be ignored.

Verification
REQ-025 The bench SHALL cover at least the following directed scenarios:
- LW at 0x0004, bus_ack in the first REQ cycle, bus_rdata = 0x8899AABB: stall = 1 for 2 cycles, done in cycle 3, rdata_W = 0x8899AABB.
- LB at 0x0007 with bus_rdata = 0x80123456: rdata_W = 0xFFFFFF80. The same access as LBU: rdata_W = 0x00000080.
- SH at 0x0002 with V2 = 0x0000BEEF: bus_byteen = 4'b1100, bus_wdata = 0xBEEFBEEF, bus_we = 1; with bus_ack delayed 4 cycles, stall = 1 for 5 cycles.
- SW at 0x7F08: no bus_req, isExc = 1 and excCode = 5 one cycle later. LW at 0x0002: excCode = 4.
- isExc_M = 1 with op LW: stall = 0, no bus_req, isExc = 0.
- Reset asserted in the 2nd REQ cycle, then bus_ack = 1: bus_req = 0 the next cycle, FSM in IDLE, done never asserted.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store engine. Validates the access in IDLE,
// drives a held bus request until the responder acknowledges, then presents
// the extended load data (DONE) or a one-cycle address exception (EXC).
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_M,
  input  logic [3:0]  op_M,
  input  logic [31:0] AO_M,
  input  logic [31:0] V2_M,
  input  logic        isExc_M,
  input  logic        isOverflow_M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] rdata_W,
  output logic        done,
  output logic        isExc,
  output logic [4:0]  excCode
);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_EXC  = 2'd3;

  logic [1:0] state;
  logic [3:0] op_p1;
  logic [1:0] lane_p1;
  logic       is_load_p0;
  logic       is_store_p0;
  logic       req_p0;
  logic       fault_p0;

  // Address legality: alignment, overflow, memory map and device restrictions
  // (devices are word-only; the last word of each device window is read-only).
  function automatic logic addr_fault(input logic [3:0] op, input logic [31:0] ao,
                                      input logic ovf);
    logic word_acc, half_acc, store_acc, in_ram, in_dev, dev_ro;
    word_acc  = (op == OP_LW) || (op == OP_SW);
    half_acc  = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    store_acc = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    in_ram    = (ao <= 32'h0000_2FFF);
    in_dev    = ((ao >= 32'h0000_7F00) && (ao <= 32'h0000_7F0B)) ||
                ((ao >= 32'h0000_7F10) && (ao <= 32'h0000_7F1B));
    dev_ro    = ((ao >= 32'h0000_7F08) && (ao <= 32'h0000_7F0B)) ||
                ((ao >= 32'h0000_7F18) && (ao <= 32'h0000_7F1B));
    addr_fault = ovf || (word_acc && (ao[1:0] != 2'b00)) || (half_acc && ao[0]) ||
                 !(in_ram || in_dev) || (in_dev && !word_acc) || (store_acc && dev_ro);
  endfunction

  function automatic logic [3:0] byteen_f(input logic [3:0] op, input logic [1:0] lo);
    case (op)
      OP_SH:   byteen_f = 4'b0011 << lo;
      OP_SB:   byteen_f = 4'b0001 << lo;
      default: byteen_f = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input logic [3:0] op, input logic [31:0] v2);
    case (op)
      OP_SH:   wdata_f = {2{v2[15:0]}};
      OP_SB:   wdata_f = {4{v2[7:0]}};
      default: wdata_f = v2;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic [15:0] half;
    logic [7:0]  byte_v;
    half = lo[1] ? word[31:16] : word[15:0];
    case (lo)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    case (op)
      OP_LH:   load_extend = {{16{half[15]}}, half};
      OP_LHU:  load_extend = {16'h0000, half};
      OP_LB:   load_extend = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_extend = {24'h000000, byte_v};
      default: load_extend = word;
    endcase
  endfunction

  // Stage p0: decode and check the M-stage instruction as it arrives
  assign is_load_p0  = (op_M >= OP_LW) && (op_M <= OP_LBU);
  assign is_store_p0 = (op_M >= OP_SW) && (op_M <= OP_SB);
  assign req_p0      = valid_M && (is_load_p0 || is_store_p0) && !isExc_M;
  assign fault_p0    = addr_fault(op_M, AO_M, isOverflow_M);

  assign bus_req = (state == S_REQ);
  assign done    = (state == S_DONE);
  assign isExc   = (state == S_EXC);
  assign stall   = ((state == S_IDLE) && req_p0) || (state == S_REQ);

  // Stage p1: FSM plus latched access; bus outputs come straight from these registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_p1      <= 4'd0;
      lane_p1    <= 2'd0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_wdata  <= 32'd0;
      bus_byteen <= 4'b0000;
      rdata_W    <= 32'd0;
      excCode    <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_p0) begin
            if (fault_p0) begin
              state   <= S_EXC;
              excCode <= is_store_p0 ? 5'd5 : 5'd4;
            end else begin
              state      <= S_REQ;
              op_p1      <= op_M;
              lane_p1    <= AO_M[1:0];
              bus_we     <= is_store_p0;
              bus_addr   <= {AO_M[31:2], 2'b00};
              bus_wdata  <= wdata_f(op_M, V2_M);
              bus_byteen <= byteen_f(op_M, AO_M[1:0]);
            end
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            state <= S_DONE;
            if (!bus_we) rdata_W <= load_extend(op_p1, lane_p1, bus_rdata);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed accesses with a scoreboard of expected
// load results / exception codes popped whenever done or isExc fires.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_M;
  logic [3:0]  op_M;
  logic [31:0] AO_M;
  logic [31:0] V2_M;
  logic        isExc_M;
  logic        isOverflow_M;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byteen;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall;
  logic [31:0] rdata_W;
  logic        done;
  logic        isExc;
  logic [4:0]  excCode;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .valid_M(valid_M), .op_M(op_M), .AO_M(AO_M), .V2_M(V2_M),
    .isExc_M(isExc_M), .isOverflow_M(isOverflow_M), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byteen(bus_byteen), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .stall(stall), .rdata_W(rdata_W), .done(done), .isExc(isExc),
    .excCode(excCode)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_exc;
    logic [31:0] val;
  } sb_t;

  sb_t         sb_q[$];
  sb_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_load = 32'd0;
  int          ack_cyc = 1;
  logic [31:0] resp_rdata = 32'd0;
  bit          resp_en = 1'b1;
  int          req_cnt = 0;

  // Responder: acknowledges in the ack_cyc-th REQ cycle
  always @(negedge clk) begin
    if (resp_en) begin
      if (bus_req) begin
        req_cnt   = req_cnt + 1;
        bus_ack   = (req_cnt >= ack_cyc);
        bus_rdata = resp_rdata;
      end else begin
        req_cnt = 0;
        bus_ack = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every done/isExc pops one expected entry
  always @(negedge clk) begin
    if (done || isExc) begin
      checks = checks + 1;
      if (sb_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sb_unexpected: done=%0b isExc=%0b but nothing expected", done, isExc);
      end else begin
        mon_e = sb_q.pop_front();
        if (isExc !== mon_e.is_exc || done === mon_e.is_exc) begin
          errors = errors + 1;
          $display("FAIL sb_kind: isExc=%0b done=%0b expected exception=%0b", isExc, done, mon_e.is_exc);
        end else if (isExc && excCode !== mon_e.val[4:0]) begin
          errors = errors + 1;
          $display("FAIL sb_excCode: got %0d expected %0d", excCode, mon_e.val[4:0]);
        end else if (done && rdata_W !== mon_e.val) begin
          errors = errors + 1;
          $display("FAIL sb_rdata_W: got %08h expected %08h", rdata_W, mon_e.val);
        end
      end
    end
  end

  task automatic run_access(input string name, input logic [3:0] op, input logic [31:0] ao,
                            input logic [31:0] v2, input logic [31:0] rd, input int ack_n,
                            input bit ovf, input bit exp_exc, input logic [31:0] exp_val,
                            input int exp_stall, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd);
    int          stall_cnt;
    int          req_seen;
    bit          got;
    bit          unstable;
    bit          is_st;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    logic        we0;
    sb_t         e;
    is_st = (op >= 4'd6) && (op <= 4'd8);
    @(negedge clk);
    ack_cyc      = ack_n;
    resp_rdata   = rd;
    valid_M      = 1'b1;
    op_M         = op;
    AO_M         = ao;
    V2_M         = v2;
    isOverflow_M = ovf;
    isExc_M      = 1'b0;
    e.is_exc = exp_exc;
    e.val    = (!exp_exc && is_st) ? last_load : exp_val;
    sb_q.push_back(e);
    if (!exp_exc && !is_st) last_load = exp_val;
    stall_cnt = 0; req_seen = 0; got = 0; unstable = 0;
    a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      #1;
      if (stall) stall_cnt++;
      if (bus_req) begin
        if (req_seen == 0) begin
          a0 = bus_addr; w0 = bus_wdata; b0 = bus_byteen; we0 = bus_we;
        end else if (bus_addr !== a0 || bus_wdata !== w0 || bus_byteen !== b0 || bus_we !== we0) begin
          unstable = 1;
        end
        req_seen++;
      end
      if (done || isExc) got = 1;
      else @(negedge clk);
    end
    valid_M      = 1'b0;
    isOverflow_M = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: no done/isExc within 50 cycles", name);
    end
    checks++;
    if (stall_cnt != exp_stall) begin
      errors++;
      $display("FAIL %s_stall: stall cycles %0d expected %0d", name, stall_cnt, exp_stall);
    end
    if (exp_exc) begin
      checks++;
      if (req_seen != 0) begin
        errors++;
        $display("FAIL %s_no_req: bus_req seen %0d cycles expected 0", name, req_seen);
      end
    end else begin
      checks++;
      if (a0 !== {ao[31:2], 2'b00} || we0 !== is_st || b0 !== exp_be) begin
        errors++;
        $display("FAIL %s_bus: addr=%08h we=%0b be=%04b expected addr=%08h we=%0b be=%04b",
                 name, a0, we0, b0, {ao[31:2], 2'b00}, is_st, exp_be);
      end
      if (is_st) begin
        checks++;
        if (w0 !== exp_wd) begin
          errors++;
          $display("FAIL %s_wdata: got %08h expected %08h", name, w0, exp_wd);
        end
      end
      checks++;
      if (unstable) begin
        errors++;
        $display("FAIL %s_hold: bus outputs changed during REQ, first addr=%08h", name, a0);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus_req !== 1'b0 || bus_we !== 1'b0 || done !== 1'b0 || isExc !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%0b we=%0b done=%0b isExc=%0b stall=%0b expected all 0",
               bus_req, bus_we, done, isExc, stall);
    end
    checks++;
    if (bus_addr !== 32'd0 || bus_wdata !== 32'd0 || rdata_W !== 32'd0 ||
        bus_byteen !== 4'b0000 || excCode !== 5'd0) begin
      errors++;
      $display("FAIL reset_data: addr=%08h wd=%08h rd=%08h be=%04b exc=%0d expected zeros",
               bus_addr, bus_wdata, rdata_W, bus_byteen, excCode);
    end
    reset = 1'b0;
    last_load = 32'd0;
  endtask

  task automatic test_lw();
    run_access("lw", 4'd1, 32'h0000_0004, 32'h0, 32'h8899AABB, 1, 0, 0, 32'h8899AABB, 2, 4'b1111, 32'h0);
    run_access("lw_dev_ro", 4'd1, 32'h0000_7F18, 32'h0, 32'h12345678, 1, 0, 0, 32'h12345678, 2, 4'b1111, 32'h0);
  endtask

  task automatic test_load_ext();
    run_access("lb",  4'd4, 32'h0000_0007, 32'h0, 32'h80123456, 1, 0, 0, 32'hFFFFFF80, 2, 4'b1111, 32'h0);
    run_access("lbu", 4'd5, 32'h0000_0007, 32'h0, 32'h80123456, 1, 0, 0, 32'h00000080, 2, 4'b1111, 32'h0);
    run_access("lh",  4'd2, 32'h0000_0002, 32'h0, 32'h80123456, 2, 0, 0, 32'hFFFF8012, 3, 4'b1111, 32'h0);
    run_access("lhu", 4'd3, 32'h0000_0000, 32'h0, 32'h80123456, 1, 0, 0, 32'h00003456, 2, 4'b1111, 32'h0);
    run_access("lb_pos", 4'd4, 32'h0000_0004, 32'h0, 32'h0000007F, 1, 0, 0, 32'h0000007F, 2, 4'b1111, 32'h0);
  endtask

  task automatic test_store();
    run_access("sh", 4'd7, 32'h0000_0002, 32'h0000BEEF, 32'hFFFFFFFF, 4, 0, 0, 32'h0, 5, 4'b1100, 32'hBEEFBEEF);
    run_access("sb", 4'd8, 32'h0000_0001, 32'h12345677, 32'h0, 1, 0, 0, 32'h0, 2, 4'b0010, 32'h77777777);
    run_access("sw", 4'd6, 32'h0000_7F10, 32'hDEADBEEF, 32'h0, 2, 0, 0, 32'h0, 3, 4'b1111, 32'hDEADBEEF);
  endtask

  task automatic test_addr_exc();
    run_access("sw_ro",   4'd6, 32'h0000_7F08, 32'h1, 32'h0, 1, 0, 1, 32'd5, 1, 4'b0, 32'h0);
    run_access("lw_mis",  4'd1, 32'h0000_0002, 32'h0, 32'h0, 1, 0, 1, 32'd4, 1, 4'b0, 32'h0);
    run_access("lhu_mis", 4'd3, 32'h0000_0001, 32'h0, 32'h0, 1, 0, 1, 32'd4, 1, 4'b0, 32'h0);
    run_access("lh_dev",  4'd2, 32'h0000_7F00, 32'h0, 32'h0, 1, 0, 1, 32'd4, 1, 4'b0, 32'h0);
    run_access("sb_oor",  4'd8, 32'h0000_3000, 32'h0, 32'h0, 1, 0, 1, 32'd5, 1, 4'b0, 32'h0);
    run_access("lw_ovf",  4'd1, 32'h0000_0100, 32'h0, 32'h0, 1, 1, 1, 32'd4, 1, 4'b0, 32'h0);
  endtask

  task automatic test_isexc_m();
    @(negedge clk);
    valid_M = 1'b1; op_M = 4'd1; AO_M = 32'h0000_0004; isExc_M = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (stall !== 1'b0 || bus_req !== 1'b0 || isExc !== 1'b0) begin
        errors++;
        $display("FAIL isexc_m_c%0d: stall=%0b bus_req=%0b isExc=%0b expected 0 0 0",
                 c, stall, bus_req, isExc);
      end
      @(negedge clk);
    end
    valid_M = 1'b0; isExc_M = 1'b0;
  endtask

  task automatic test_reset_in_req();
    resp_en = 1'b0;
    bus_ack = 1'b0;
    @(negedge clk);
    valid_M = 1'b1; op_M = 4'd1; AO_M = 32'h0000_0010; V2_M = 32'h0;
    @(negedge clk);
    #1;
    checks++;
    if (bus_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_req_enter: bus_req=%0b expected 1", bus_req);
    end
    @(negedge clk);
    reset = 1'b1;
    valid_M = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus_ack = 1'b1;
    #1;
    checks++;
    if (bus_req !== 1'b0 || stall !== 1'b0 || bus_addr !== 32'd0) begin
      errors++;
      $display("FAIL rst_req_drop: bus_req=%0b stall=%0b addr=%08h expected 0 0 00000000",
               bus_req, stall, bus_addr);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || bus_req !== 1'b0 || isExc !== 1'b0) begin
        errors++;
        $display("FAIL rst_ack_ignored_c%0d: done=%0b bus_req=%0b isExc=%0b expected 0 0 0",
                 c, done, bus_req, isExc);
      end
    end
    bus_ack = 1'b0;
    resp_en = 1'b1;
    last_load = 32'd0;
  endtask

  task automatic test_back_to_back();
    run_access("b2b_ram_top", 4'd1, 32'h0000_2FFC, 32'h0, 32'hCAFEF00D, 1, 0, 0, 32'hCAFEF00D, 2, 4'b1111, 32'h0);
    run_access("b2b_dev",     4'd1, 32'h0000_7F00, 32'h0, 32'h0BADC0DE, 3, 0, 0, 32'h0BADC0DE, 4, 4'b1111, 32'h0);
    run_access("b2b_exc",     4'd1, 32'h0000_7F0C, 32'h0, 32'h0, 1, 0, 1, 32'd4, 1, 4'b0, 32'h0);
    run_access("b2b_sw",      4'd6, 32'h0000_0008, 32'h55AA55AA, 32'h0, 1, 0, 0, 32'h0, 2, 4'b1111, 32'h55AA55AA);
  endtask

  initial begin
    reset = 1'b1; valid_M = 1'b0; op_M = 4'd0; AO_M = 32'd0; V2_M = 32'd0;
    isExc_M = 1'b0; isOverflow_M = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0;
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_addr_exc();
    test_isexc_m();
    test_reset_in_req();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected entries never produced, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
